dcache_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_data_ram.sv | 25 ++
 rtl/dcache_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Holds the cache geometry (LINES, WORDS_PER_LINE), the address-split widths
// derived from it, the controller state enum and the per-line metadata struct.
package dcache_pkg;

  localparam int unsigned LINES          = 64;  // power of two
  localparam int unsigned WORDS_PER_LINE = 4;   // power of two, >= 2
  localparam int unsigned WORD_W         = 32;

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned OB    = OFF_W + 2;
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - OB - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_meta_t;

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data array: single-port, combinational read, synchronous write.
// Ports: clk; we/addr/wdata write port; rdata = word at addr (same address).
// Contents are deliberately not reset.
import dcache_pkg::*;

module dcache_data_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-back / write-allocate data cache controller.
// Ports:
//   clk, rst (synchronous, active-high)
//   cpu_valid/cpu_we/cpu_addr/cpu_wdata : access from EX/MEM
//   cpu_rdata, D_cache_stall            : combinational load data and stall
//   mem_req/mem_we/mem_addr/mem_wdata   : registered word-serial memory bus
//   mem_rdata/mem_ack                   : memory response
//   hit_cnt/miss_cnt                    : performance counters
// Optional: define DCACHE_PERF_EN to build the hit/miss counters; otherwise
// both counter ports read 0 and no counter flops exist.
import dcache_pkg::*;

module dcache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        D_cache_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  logic [OFF_W-1:0] cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             unused_addr_bits;

  assign cpu_off          = cpu_addr[OB-1:2];
  assign cpu_idx          = cpu_addr[OB+IDX_W-1:OB];
  assign cpu_tag          = cpu_addr[31:OB+IDX_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  state_t           state;
  line_meta_t       meta [LINES];
  logic [OFF_W-1:0] cnt;
  logic [IDX_W-1:0] lat_idx;
  logic [OFF_W-1:0] lat_off;
  logic [TAG_W-1:0] lat_tag;
  logic             lat_we;
  logic [31:0]      lat_wdata;

  line_meta_t cur_meta;
  line_meta_t vic_meta;
  logic       hit;
  logic       miss;
  logic       acked;
  logic       last;
  logic [OFF_W-1:0] cnt_nxt;

  assign cur_meta = meta[cpu_idx];
  assign vic_meta = meta[lat_idx];
  assign hit      = (state == IDLE) && cpu_valid && cur_meta.valid && (cur_meta.tag == cpu_tag);
  assign miss     = (state == IDLE) && cpu_valid && !hit;
  assign acked    = mem_req && mem_ack;
  assign last     = (cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign cnt_nxt  = cnt + OFF_W'(1);

  logic [IDX_W-1:0] ram_idx;
  logic [OFF_W-1:0] ram_off;
  logic             ram_we;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  // Single data-array port: who drives the address depends on the state.
  // In WB the read runs one word ahead on an ack so mem_wdata can be reloaded
  // at the same edge, keeping mem_req continuous across the burst.
  always_comb begin
    ram_idx   = cpu_idx;
    ram_off   = cpu_off;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    case (state)
      IDLE: ram_we = hit && cpu_we;
      WB: begin
        ram_idx = lat_idx;
        ram_off = acked ? cnt_nxt : cnt;
      end
      REFILL: begin
        ram_idx   = lat_idx;
        ram_off   = cnt;
        ram_we    = acked;
        ram_wdata = mem_rdata;
      end
      DONE: begin
        ram_idx   = lat_idx;
        ram_off   = lat_off;
        ram_we    = lat_we;
        ram_wdata = lat_wdata;
      end
      default: ram_we = 1'b0;
    endcase
  end

  // Stall is raised in the cycle the miss is seen and released in DONE.
  always_comb begin
    D_cache_stall = 1'b0;
    case (state)
      IDLE:       D_cache_stall = miss;
      WB, REFILL: D_cache_stall = 1'b1;
      default:    D_cache_stall = 1'b0;
    endcase
  end

  assign cpu_rdata = (hit || (state == DONE)) ? ram_rdata : 32'd0;

  dcache_data_ram #(
    .DEPTH (LINES * WORDS_PER_LINE),
    .AW    (IDX_W + OFF_W)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  ({ram_idx, ram_off}),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Controller FSM. Each burst state opens with mem_req low for one cycle,
  // which gives the mandatory gap between WB and REFILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_idx   <= '0;
      lat_off   <= '0;
      lat_tag   <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      for (int unsigned i = 0; i < LINES; i++) meta[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            lat_idx   <= cpu_idx;
            lat_off   <= cpu_off;
            lat_tag   <= cpu_tag;
            lat_we    <= cpu_we;
            lat_wdata <= cpu_wdata;
            cnt       <= '0;
            state     <= (cur_meta.valid && cur_meta.dirty) ? WB : REFILL;
          end else if (hit && cpu_we) begin
            meta[cpu_idx].dirty <= 1'b1;
          end
        end
        WB: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {vic_meta.tag, lat_idx, cnt, 2'b00};
            mem_wdata <= ram_rdata;
          end else if (mem_ack) begin
            if (last) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              cnt     <= '0;
              state   <= REFILL;
            end else begin
              cnt       <= cnt_nxt;
              mem_addr  <= {vic_meta.tag, lat_idx, cnt_nxt, 2'b00};
              mem_wdata <= ram_rdata;
            end
          end
        end
        REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {lat_tag, lat_idx, cnt, 2'b00};
          end else if (mem_ack) begin
            if (last) begin
              mem_req       <= 1'b0;
              cnt           <= '0;
              meta[lat_idx] <= '{valid: 1'b1, dirty: 1'b0, tag: lat_tag};
              state         <= DONE;
            end else begin
              cnt      <= cnt_nxt;
              mem_addr <= {lat_tag, lat_idx, cnt_nxt, 2'b00};
            end
          end
        end
        DONE: begin
          if (lat_we) meta[lat_idx].dirty <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  // Hits count only in IDLE; the completing DONE cycle of a miss is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by a
// randomized access stream, checked against an architectural memory image
// plus a per-index residency table. A bench-side memory answers the bus.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        D_cache_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_valid     (cpu_valid),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .D_cache_stall (D_cache_stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 2;

  logic [31:0] mem_model [logic [31:0]];  // contents of main memory
  logic [31:0] golden    [logic [31:0]];  // architectural value seen by the CPU
  logic [31:0] rd_addr_q [$];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  bit          m_valid [64];
  bit          m_dirty [64];
  logic [21:0] m_tag   [64];
  int          hits_m;
  int          misses_m;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : mem_default(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks each requested word after `lat` idle cycles.
  initial begin
    int wait_c;
    wait_c    = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0;
        wait_c  = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        wait_c  = 0;
      end else if (mem_req) begin
        if (wait_c >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_rd(mem_addr);
            rd_addr_q.push_back(mem_addr);
          end
        end else begin
          wait_c++;
        end
      end else begin
        wait_c = 0;
      end
    end
  end

  task automatic model_reset();
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    golden   = mem_model;  // dirty lines are lost on reset
    hits_m   = 0;
    misses_m = 0;
  endtask

  // One CPU access, held until the stall releases, checked against the model.
  task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    logic [31:0] wa, base, vbase, exp_rd, rd_first, rd;
    logic [5:0]  idx;
    logic [21:0] tg;
    bit          exp_miss, exp_wb, st_first;
    int          cyc;
    wa       = {addr[31:2], 2'b00};
    idx      = wa[9:4];
    tg       = wa[31:10];
    base     = {wa[31:4], 4'h0};
    exp_miss = !(m_valid[idx] && m_tag[idx] == tg);
    exp_wb   = exp_miss && m_valid[idx] && m_dirty[idx];
    vbase    = {m_tag[idx], idx, 4'h0};
    exp_rd   = gold_rd(wa);
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();

    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    st_first = D_cache_stall;
    rd_first = cpu_rdata;
    cyc      = 0;
    while (D_cache_stall && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("stall_release", 32'(D_cache_stall), 32'd0);
    rd = cpu_rdata;
    @(negedge clk);
    cpu_valid = 1'b0;

    check("miss_detect", 32'(st_first), 32'(exp_miss));
    if (exp_miss) check("rdata_zero_on_miss", rd_first, 32'd0);
    if (!we) check("load_data", rd, exp_rd);
    check("wb_words", 32'(wr_addr_q.size()), exp_wb ? 32'd4 : 32'd0);
    for (int k = 0; k < wr_addr_q.size() && k < 4; k++) begin
      check("wb_addr", wr_addr_q[k], vbase + 32'(4 * k));
      check("wb_data", wr_data_q[k], gold_rd(vbase + 32'(4 * k)));
    end
    check("refill_words", 32'(rd_addr_q.size()), exp_miss ? 32'd4 : 32'd0);
    for (int k = 0; k < rd_addr_q.size() && k < 4; k++)
      check("refill_addr", rd_addr_q[k], base + 32'(4 * k));

    if (exp_miss) begin
      misses_m++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end else begin
      hits_m++;
    end
    if (we) begin
      golden[wa]   = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  idx_pool [4];
    logic [31:0] a;
    int          cyc;
    idx_pool = '{6'h03, 6'h10, 6'h20, 6'h3F};

    rst       = 1'b1;
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    for (int k = 0; k < 4; k++) mem_model[32'h100 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(D_cache_stall), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load, hit, store hit, dirty eviction, store miss, store eviction
    lat = 2;
    do_access(32'h0000_0100, 1'b0, 32'd0);
    do_access(32'h0000_0104, 1'b0, 32'd0);
    do_access(32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
    do_access(32'h0000_0500, 1'b0, 32'd0);
    do_access(32'h0000_0200, 1'b1, 32'h1234_5678);
    do_access(32'h0000_0200, 1'b0, 32'd0);
    do_access(32'h0000_0600, 1'b0, 32'd0);
    check("mem_holds_store", mem_rd(32'h0000_0200), 32'h1234_5678);

    // Reset while the third refill word is outstanding
    rd_addr_q.delete();
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0000_0100;
    cyc       = 0;
    #1;
    while (!(rd_addr_q.size() == 2 && mem_req && !mem_ack) && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("reach_third_word", 32'(rd_addr_q.size()), 32'd2);
    rst       = 1'b1;
    cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_stall", 32'(D_cache_stall), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reload misses again, then three hits
    do_access(32'h0000_0100, 1'b0, 32'd0);
    do_access(32'h0000_0104, 1'b0, 32'd0);
    do_access(32'h0000_0108, 1'b0, 32'd0);
    do_access(32'h0000_010C, 1'b0, 32'd0);
`ifdef DCACHE_PERF_EN
    check("miss_cnt_1", miss_cnt, 32'd1);
    check("hit_cnt_3", hit_cnt, 32'd3);
`else
    check("miss_cnt_off", miss_cnt, 32'd0);
    check("hit_cnt_off", hit_cnt, 32'd0);
`endif

    // Randomized conflicting traffic over a few indices and tags
    for (int n = 0; n < 250; n++) begin
      lat = int'($urandom_range(0, 2));
      a   = {22'($urandom_range(0, 3)), idx_pool[$urandom_range(0, 3)],
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_access(a, 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef DCACHE_PERF_EN
    check("hit_cnt_final", hit_cnt, 32'(hits_m));
    check("miss_cnt_final", miss_cnt, 32'(misses_m));
`else
    check("hit_cnt_final_off", hit_cnt, 32'd0);
    check("miss_cnt_final_off", miss_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
